// File: rtl/mpc_constraint_vec_build.sv
// mpc_constraint_vec_build: streams len source words through a saturating copy/negate/bound transform into h at dst_base.
module mpc_constraint_vec_build #(
  parameter int DATA_W    = 32,
  parameter int SRC_DEPTH = 8,
  parameter int SRC_AW    = 3,
  parameter int DST_AW    = 5,
  parameter int LEN_W     = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic [DST_AW-1:0] dst_base,
  input  logic [DATA_W-1:0] bnd,
  output logic [SRC_AW-1:0] f_address0,
  output logic              f_ce0,
  input  logic [DATA_W-1:0] f_q0,
  output logic [DST_AW-1:0] h_address0,
  output logic              h_ce0,
  output logic              h_we0,
  output logic [DATA_W-1:0] h_d0,
  output logic              sat
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0]  i_q, i_d, eff_len_q, len_c;
  logic [1:0]        mode_q;
  logic [DST_AW-1:0] base_q, w_a_q;
  logic [DATA_W-1:0] bnd_q, w_d_q, res;
  logic [SRC_AW-1:0] rd_k_q;
  logic              rd_v_q, w_v_q, sat_q, accept, ovf;
  logic [DATA_W:0]   fx, bx, r;
  assign len_c  = len > LEN_W'(SRC_DEPTH) ? LEN_W'(SRC_DEPTH) : len;
  assign accept = state_q == IDLE && ap_start && !ap_rst;
  // Widen by one bit so negate/subtract cannot wrap before the clamp.
  assign fx  = {f_q0[DATA_W-1], f_q0};
  assign bx  = {bnd_q[DATA_W-1], bnd_q};
  assign r   = mode_q == 2'd0 ? fx : mode_q == 2'd1 ? -fx : mode_q == 2'd2 ? bx - fx : fx - bx;
  assign ovf = r[DATA_W] ^ r[DATA_W-1];
  assign res = ovf ? {r[DATA_W], {(DATA_W-1){~r[DATA_W]}}} : r[DATA_W-1:0];
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    f_ce0      = 1'b0;
    f_address0 = SRC_AW'(i_q);
    ap_ready   = 1'b0;
    ap_done    = 1'b0;
    case (state_q)
      IDLE: begin
        f_address0 = '0;
        if (accept) begin
          f_ce0    = len_c != '0;
          ap_ready = len_c <= LEN_W'(1);
          i_d      = LEN_W'(1);
          state_d  = len_c > LEN_W'(1) ? RUN : DRAIN;
        end
      end
      RUN: begin
        f_ce0 = 1'b1;
        i_d   = i_q + LEN_W'(1);
        if (i_q == eff_len_q - LEN_W'(1)) begin
          ap_ready = 1'b1;
          state_d  = DRAIN;
        end
      end
      default: begin
        ap_done = !rd_v_q;
        state_d = rd_v_q ? DRAIN : IDLE;
      end
    endcase
    if (ap_rst) begin
      f_ce0    = 1'b0;
      ap_ready = 1'b0;
      ap_done  = 1'b0;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      eff_len_q <= '0;
      mode_q    <= '0;
      base_q    <= '0;
      bnd_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_k_q    <= '0;
      w_v_q     <= 1'b0;
      w_a_q     <= '0;
      w_d_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rd_v_q  <= f_ce0;
      rd_k_q  <= f_address0;
      w_v_q   <= rd_v_q;
      sat_q   <= accept ? 1'b0 : sat_q | (rd_v_q & ovf);
      if (rd_v_q) begin
        w_a_q <= base_q + DST_AW'(rd_k_q);
        w_d_q <= res;
      end
      if (accept) begin
        eff_len_q <= len_c;
        mode_q    <= mode;
        base_q    <= dst_base;
        bnd_q     <= bnd;
      end
    end
  end
  assign ap_idle    = state_q == IDLE && !rd_v_q && !w_v_q && !accept;
  assign h_we0      = w_v_q & ~ap_rst;
  assign h_ce0      = h_we0;
  assign h_address0 = w_a_q;
  assign h_d0       = w_d_q;
  assign sat        = sat_q;
endmodule

// File: tb/tb_mpc_constraint_vec_build.sv
// tb_mpc_constraint_vec_build: table, directed and random runs against an integer-arithmetic model with RAM models.
module tb_mpc_constraint_vec_build;
  logic        clk = 0, rst = 1, ap_start = 0;
  logic        ap_done, ap_idle, ap_ready, f_ce0, h_ce0, h_we0, sat;
  logic [1:0]  mode = 0;
  logic [3:0]  len = 0;
  logic [4:0]  dst_base = 0, h_address0;
  logic [31:0] bnd = 0, f_q0 = 0, h_d0;
  logic [2:0]  f_address0;
  logic [31:0] fmem [0:7];
  logic [31:0] hmem [0:31];
  int checks = 0, errors = 0;

  mpc_constraint_vec_build dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .mode(mode), .len(len), .dst_base(dst_base), .bnd(bnd),
    .f_address0(f_address0), .f_ce0(f_ce0), .f_q0(f_q0), .h_address0(h_address0),
    .h_ce0(h_ce0), .h_we0(h_we0), .h_d0(h_d0), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (f_ce0) f_q0 <= fmem[f_address0];
  always @(posedge clk) if (h_we0) hmem[h_address0] <= h_d0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // Exact integer result, then clamp to the signed 32-bit range.
  function automatic logic [31:0] ref_elem(input logic [1:0] m, input logic [31:0] f,
                                           input logic [31:0] b, output logic s);
    longint fv, bv, v, maxv, minv;
    maxv = (longint'(1) <<< 31) - 1;
    minv = -(longint'(1) <<< 31);
    fv = longint'($signed(f));
    bv = longint'($signed(b));
    v = m == 0 ? fv : m == 1 ? -fv : m == 2 ? bv - fv : fv - bv;
    s = v > maxv || v < minv;
    if (v > maxv) v = maxv;
    if (v < minv) v = minv;
    return v[31:0];
  endfunction

  task automatic do_run(input logic [1:0] m, input logic [3:0] l, input logic [4:0] b, input logic [31:0] bd);
    int n, rc, dc;
    logic es, s;
    logic [31:0] ed;
    n  = l > 8 ? 8 : int'(l);
    rc = n == 0 ? 0 : n - 1;
    dc = n + 1;
    es = 0;
    @(posedge clk); #1;
    mode = m; len = l; dst_base = b; bnd = bd; ap_start = 1;
    for (int c = 0; c <= dc; c++) begin
      @(negedge clk);
      if (c == 0) chk("idle_acc", ap_idle, 0);
      if (c == 1) chk("sat_clr", sat, 0);
      chk("f_ce0", f_ce0, c < n);
      if (c < n) chk("f_addr", f_address0, c);
      chk("h_we0", h_we0, c >= 2 && c < n + 2);
      if (c >= 2 && c < n + 2) begin
        ed = ref_elem(m, fmem[c-2], bd, s);
        es |= s;
        chk("h_addr", h_address0, (b + c - 2) % 32);
        chk("h_d0", h_d0, ed);
        chk("h_ce0", h_ce0, 1);
      end
      chk("ready", ap_ready, c == rc);
      chk("done", ap_done, c == dc);
      @(posedge clk); #1;
      ap_start = 0;
      mode = 2'($urandom); len = 4'($urandom); dst_base = 5'($urandom); bnd = $urandom;
    end
    @(negedge clk);
    chk("idle_end", ap_idle, 1);
    chk("sat", sat, es);
  endtask

  typedef struct {logic [1:0] m; logic [31:0] f, b, eh; logic es;} vec_t;
  vec_t tbl [10];
  logic [5:0] ce_e, we_e, rdy_e, dn_e;

  initial begin
    tbl[0] = '{1, 32'h80000000, 0,            32'h7FFFFFFF, 1};
    tbl[1] = '{3, 32'h7FFFFFFF, 1,            32'h7FFFFFFE, 0};
    tbl[2] = '{3, 32'h80000000, 1,            32'h80000000, 1};
    tbl[3] = '{0, 32'h12345678, 0,            32'h12345678, 0};
    tbl[4] = '{1, 32'h00000005, 0,            32'hFFFFFFFB, 0};
    tbl[5] = '{2, 32'h80000000, 0,            32'h7FFFFFFF, 1};
    tbl[6] = '{2, 32'h00000001, 32'h7FFFFFFF, 32'h7FFFFFFE, 0};
    tbl[7] = '{3, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 1};
    tbl[8] = '{2, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 1};
    tbl[9] = '{1, 32'h80000001, 0,            32'h7FFFFFFF, 0};
    for (int i = 0; i < 8; i++) fmem[i] = i + 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_fce", f_ce0, 0);
    chk("rst_hwe", h_we0, 0);
    chk("rst_sat", sat, 0);
    chk("rst_haddr", h_address0, 0);
    chk("rst_hd", h_d0, 0);
    chk("rst_faddr", f_address0, 0);

    do_run(0, 8, 0, 0);
    for (int i = 0; i < 8; i++) chk("copy_h", hmem[i], i + 1);

    fmem[0] = 10; fmem[1] = -32'sd5; fmem[2] = 32'h7FFFFFFF;
    do_run(2, 3, 8, 100);
    chk("bnd_h8", hmem[8], 90);
    chk("bnd_h9", hmem[9], 105);
    chk("bnd_h10", hmem[10], 32'h80000065);

    for (int i = 0; i < 10; i++) begin
      fmem[0] = tbl[i].f;
      do_run(tbl[i].m, 1, 5'(i + 12), tbl[i].b);
      chk("tbl_h", hmem[i + 12], tbl[i].eh);
      chk("tbl_sat", sat, tbl[i].es);
    end

    for (int i = 0; i < 8; i++) fmem[i] = 32'h100 + i;
    do_run(0, 15, 30, 0);
    chk("wrap_h31", hmem[31], 32'h101);
    chk("wrap_h5", hmem[5], 32'h107);

    // len 0 then back-to-back len 2 with start held
    ce_e = 6'b001100; we_e = 6'b110000; rdy_e = 6'b001001; dn_e = 6'b100010;
    @(posedge clk); #1;
    mode = 0; len = 0; dst_base = 20; ap_start = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_ce", f_ce0, ce_e[c]);
      chk("b2b_we", h_we0, we_e[c]);
      chk("b2b_rdy", ap_ready, rdy_e[c]);
      chk("b2b_done", ap_done, dn_e[c]);
      if (we_e[c]) chk("b2b_addr", h_address0, 20 + c - 4);
      @(posedge clk); #1;
      if (c == 0) len = 2;
      if (c == 2) ap_start = 0;
    end
    chk("b2b_h20", hmem[20], 32'h100);
    chk("b2b_h21", hmem[21], 32'h101);

    // reset asserted in cycle 4 of an 8-element run
    @(posedge clk); #1;
    mode = 0; len = 8; dst_base = 0; ap_start = 1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c < 4) chk("rm_we", h_we0, c >= 2);
      if (c >= 4) chk("rm_we_off", h_we0, 0);
      if (c >= 4) chk("rm_done", ap_done, 0);
      if (c == 4) chk("rm_fce", f_ce0, 0);
      if (c == 5) chk("rm_idle", ap_idle, 1);
      @(posedge clk); #1;
      ap_start = 0;
      rst = c == 3;
    end
    for (int i = 0; i < 8; i++) fmem[i] = 32'h55 * (i + 1);
    do_run(0, 8, 0, 0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++)
        fmem[i] = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF) : $urandom;
      do_run(2'($urandom), 4'($urandom), 5'($urandom),
             $urandom_range(0, 2) == 0 ? 32'h80000000 : $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
